serv_dbus_lsu: RTL and testbench

- Bit-serial load/store unit sitting directly downstream of the address buffer register.
- Takes the word-aligned data-bus address and byte offset produced by the address buffer, plus serially shifted store data.
- Runs one Wishbone-style data-bus cycle.
- Returns load data bit-serially, aligned and sign/zero-extended, to the register-file write path.

---
 rtl/serv_dbus_lsu.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_serv_dbus_lsu.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_dbus_lsu.sv
// -----------------------------------------------------------------------------
// serv_dbus_lsu
//
// Bit-serial load/store unit placed directly after the address buffer. Store
// data is shifted in one bit per enabled cycle while idle; a request then runs
// a single Wishbone-style data-bus cycle. Load data comes back from the bus
// and is returned one bit per enabled cycle, LSB first. It is aligned to the
// byte offset and sign- or zero-extended to 32 bits.
//
// Parameters
//   W          serial datapath width (only 1 is supported)
//   ALIGN_CHK  1 = refuse misaligned half/word accesses, 0 = issue as-is
//
// Optional feature
//   SERV_DBUS_ERR_EN  when defined, adds i_dbus_err / o_dbus_err. A bus error
//                     ends the cycle. It takes priority over a simultaneous
//                     ack. No o_done pulse is produced and the load read-out
//                     phase is skipped.
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_en                 serial step enable (one data bit per cycle)
//   i_wdat_en            shift store data in while idle
//   i_rs2                serial store data, LSB first
//   i_req                start a memory operation (1-cycle pulse, idle only)
//   i_we                 1 = store, 0 = load
//   i_funct3             [1:0] size 00/01/10 = byte/half/word, [2] unsigned
//   i_lsb                byte offset within the word
//   i_adr                word-aligned address
//   o_rd                 serial load result
//   o_done               1-cycle pulse, bus cycle finished by ack
//   o_misalign           1-cycle pulse, request refused
//   o_busy               unit is not idle
//   o_dbus_*             Wishbone-style master outputs (adr/dat/sel/we/cyc)
//   i_dbus_rdt           bus read data
//   i_dbus_ack           bus acknowledge
// -----------------------------------------------------------------------------
module serv_dbus_lsu #(
  parameter int unsigned W         = 1,
  parameter bit          ALIGN_CHK = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_wdat_en,
  input  logic [W-1:0]  i_rs2,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [2:0]    i_funct3,
  input  logic [1:0]    i_lsb,
  input  logic [31:0]   i_adr,
  output logic [W-1:0]  o_rd,
  output logic          o_done,
  output logic          o_misalign,
  output logic          o_busy,
  output logic [31:0]   o_dbus_adr,
  output logic [31:0]   o_dbus_dat,
  output logic [3:0]    o_dbus_sel,
  output logic          o_dbus_we,
  output logic          o_dbus_cyc,
`ifdef SERV_DBUS_ERR_EN
  input  logic          i_dbus_err,
  output logic          o_dbus_err,
`endif
  input  logic [31:0]   i_dbus_rdt,
  input  logic          i_dbus_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDOUT = 2'd2
  } state_e;

  // Byte enables for a given access size and byte offset.
  function automatic logic [3:0] sel_f(input logic [1:0] size, input logic [1:0] lsb);
    logic [3:0] sel_v;
    case (size)
      2'b00:   sel_v = 4'b0001 << lsb;
      2'b01:   sel_v = 4'b0011 << lsb;
      default: sel_v = 4'b1111;
    endcase
    return sel_v;
  endfunction

  // Store data replicated across lanes so any byte enable sees the right bits.
  function automatic logic [31:0] wdat_f(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] dat_v;
    case (size)
      2'b00:   dat_v = {4{data[7:0]}};
      2'b01:   dat_v = {2{data[15:0]}};
      default: dat_v = data;
    endcase
    return dat_v;
  endfunction

  // Access does not fit naturally inside its word.
  function automatic logic misalign_f(input logic [1:0] size, input logic [1:0] lsb);
    logic mis_v;
    case (size)
      2'b00:   mis_v = 1'b0;
      2'b01:   mis_v = lsb[0];
      default: mis_v = (lsb != 2'b00);
    endcase
    return mis_v;
  endfunction

  // Counter value of the last valid (sign-carrying) bit for an access size.
  function automatic logic [4:0] last_bit_f(input logic [1:0] size);
    logic [4:0] last_v;
    case (size)
      2'b00:   last_v = 5'd7;
      2'b01:   last_v = 5'd15;
      default: last_v = 5'd31;
    endcase
    return last_v;
  endfunction

  state_e      state_r;
  state_e      state_nx_s;
  logic [31:0] data_r;
  logic [4:0]  cnt_r;
  logic        sign_r;
  logic [1:0]  lsb_r;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [31:0] adr_r;
  logic [31:0] dat_r;
  logic [3:0]  sel_r;
  logic        dbus_we_r;
  logic        cyc_r;
  logic        done_r;
  logic        misalign_r;
  logic        busy_r;

  logic        bus_err_s;
  logic        mis_s;
  logic        req_take_s;
  logic        req_ok_s;
  logic        req_bad_s;
  logic        ack_end_s;
  logic        err_end_s;
  logic        step_s;
  logic        shift_in_s;
  logic        rd_s;

`ifdef SERV_DBUS_ERR_EN
  assign bus_err_s = i_dbus_err;
`else
  assign bus_err_s = 1'b0;
`endif

  assign mis_s      = ALIGN_CHK && misalign_f(i_funct3[1:0], i_lsb);
  assign req_take_s = (state_r == IDLE) && i_req;
  assign req_ok_s   = req_take_s && !mis_s;
  assign req_bad_s  = req_take_s && mis_s;
  assign ack_end_s  = (state_r == BUS) && i_dbus_ack && !bus_err_s;
  assign err_end_s  = (state_r == BUS) && bus_err_s;
  assign step_s     = (state_r == RDOUT) && i_en;
  // A request takes priority over a store-data shift in the same cycle.
  assign shift_in_s = (state_r == IDLE) && i_en && i_wdat_en && !i_req;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_ok_s) begin
          state_nx_s = BUS;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUS: begin
        if (err_end_s) begin
          state_nx_s = IDLE;
        end else if (ack_end_s) begin
          state_nx_s = we_r ? IDLE : RDOUT;
        end else begin
          state_nx_s = BUS;
        end
      end
      RDOUT: begin
        // Counter wraps 31 -> 0 on the final bit.
        if (step_s && (cnt_r == 5'd31)) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RDOUT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Request latch, bus master registers, status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lsb_r      <= 2'b00;
      we_r       <= 1'b0;
      funct3_r   <= 3'b000;
      adr_r      <= 32'h0000_0000;
      dat_r      <= 32'h0000_0000;
      sel_r      <= 4'b0000;
      dbus_we_r  <= 1'b0;
      cyc_r      <= 1'b0;
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      done_r     <= ack_end_s;
      misalign_r <= req_bad_s;
      busy_r     <= (state_nx_s != IDLE);
      if (req_take_s) begin
        lsb_r    <= i_lsb;
        we_r     <= i_we;
        funct3_r <= i_funct3;
      end
      // Bus outputs are loaded once at request time and held until the cycle ends.
      if (req_ok_s) begin
        adr_r     <= i_adr;
        sel_r     <= sel_f(i_funct3[1:0], i_lsb);
        dat_r     <= wdat_f(i_funct3[1:0], data_r);
        dbus_we_r <= i_we;
        cyc_r     <= 1'b1;
      end else if (ack_end_s || err_end_s) begin
        dbus_we_r <= 1'b0;
        cyc_r     <= 1'b0;
      end
    end
  end

  // Shared data shift register: store data in, load data out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_r <= 32'h0000_0000;
      cnt_r  <= 5'd0;
      sign_r <= 1'b0;
    end else begin
      if (ack_end_s && !we_r) begin
        // Align the addressed byte/half down to bit 0 before read-out.
        data_r <= i_dbus_rdt >> {lsb_r, 3'b000};
        cnt_r  <= 5'd0;
        sign_r <= 1'b0;
      end else if (step_s) begin
        data_r <= {1'b0, data_r[31:1]};
        cnt_r  <= cnt_r + 5'd1;
        if (cnt_r == last_bit_f(funct3_r[1:0])) begin
          sign_r <= data_r[0];
        end
      end else if (shift_in_s) begin
        data_r <= {i_rs2[0], data_r[31:1]};
      end
    end
  end

`ifdef SERV_DBUS_ERR_EN
  logic err_r;

  // Bus error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_end_s;
    end
  end

  assign o_dbus_err = err_r;
`endif

  // Serial load bit: real data up to the access size, then the extension bit.
  always_comb begin
    rd_s = 1'b0;
    if (state_r == RDOUT) begin
      if (cnt_r <= last_bit_f(funct3_r[1:0])) begin
        rd_s = data_r[0];
      end else begin
        rd_s = funct3_r[2] ? 1'b0 : sign_r;
      end
    end else begin
      rd_s = 1'b0;
    end
  end

  assign o_rd       = W'(rd_s);
  assign o_done     = done_r;
  assign o_misalign = misalign_r;
  assign o_busy     = busy_r;
  assign o_dbus_adr = adr_r;
  assign o_dbus_dat = dat_r;
  assign o_dbus_sel = sel_r;
  assign o_dbus_we  = dbus_we_r;
  assign o_dbus_cyc = cyc_r;

endmodule

// File: tb/tb_serv_dbus_lsu.sv
module tb_serv_dbus_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en, i_wdat_en, i_req, i_we;
  logic [0:0]  i_rs2;
  logic [2:0]  i_funct3;
  logic [1:0]  i_lsb;
  logic [31:0] i_adr;
  logic [0:0]  o_rd;
  logic        o_done, o_misalign, o_busy;
  logic [31:0] o_dbus_adr, o_dbus_dat;
  logic [3:0]  o_dbus_sel;
  logic        o_dbus_we, o_dbus_cyc;
  logic [31:0] i_dbus_rdt;
  logic        i_dbus_ack;
`ifdef SERV_DBUS_ERR_EN
  logic        i_dbus_err, o_dbus_err;
`endif

  always #5 i_clk = ~i_clk;

  serv_dbus_lsu #(.W(1), .ALIGN_CHK(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_wdat_en(i_wdat_en),
    .i_rs2(i_rs2), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
    .i_lsb(i_lsb), .i_adr(i_adr), .o_rd(o_rd), .o_done(o_done),
    .o_misalign(o_misalign), .o_busy(o_busy), .o_dbus_adr(o_dbus_adr),
    .o_dbus_dat(o_dbus_dat), .o_dbus_sel(o_dbus_sel), .o_dbus_we(o_dbus_we),
    .o_dbus_cyc(o_dbus_cyc),
`ifdef SERV_DBUS_ERR_EN
    .i_dbus_err(i_dbus_err), .o_dbus_err(o_dbus_err),
`endif
    .i_dbus_rdt(i_dbus_rdt), .i_dbus_ack(i_dbus_ack)
  );

  typedef struct { logic [31:0] adr; logic [3:0] sel; logic [31:0] dat; logic we; } bus_t;
  typedef struct { logic is_load; logic [31:0] rd; } done_t;

  bus_t  exp_bus_q[$];
  done_t exp_done_q[$];
  int    exp_mis_q[$];
  int    exp_err_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] size);
    if (size == 2'd0) return 1;
    else if (size == 2'd1) return 2;
    else return 4;
  endfunction

  function automatic logic model_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return (int'(lsb) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_sel(input logic [1:0] size, input logic [1:0] lsb);
    int s;
    s = ((1 << nbytes(size)) - 1) << lsb;
    return s[3:0];
  endfunction

  function automatic logic [31:0] model_dat(input logic [1:0] size, input logic [31:0] rs2);
    logic [31:0] b, h;
    b = {24'h0, rs2[7:0]};
    h = {16'h0, rs2[15:0]};
    if (nbytes(size) == 1) return b * 32'h0101_0101;
    else if (nbytes(size) == 2) return h * 32'h0001_0001;
    else return rs2;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdt, input logic [1:0] lsb,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] v, mask;
    int bits;
    v = rdt >> (8 * lsb);
    bits = 8 * nbytes(size);
    if (bits < 32) begin
      mask = (32'd1 << bits) - 32'd1;
      v = v & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic shift_rs2(input logic [31:0] v);
    for (int i = 0; i < 32; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        i_en = 1'($urandom_range(0, 1));
        i_wdat_en = i_en ? 1'b0 : 1'($urandom_range(0, 1));
        i_rs2 = 1'($urandom_range(0, 1));
        tick();
      end
      i_en = 1'b1; i_wdat_en = 1'b1; i_rs2 = v[i];
      tick();
    end
    i_en = 1'b0; i_wdat_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (o_busy && guard < 400) begin
      i_en = 1'($urandom_range(0, 1));
      i_wdat_en = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    i_en = 1'b0; i_wdat_en = 1'b0;
    check(name, o_busy, 1'b0);
  endtask

  // One memory operation; expectations are queued before stimulus starts.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [1:0] lsb,
                        input logic [31:0] adr, input logic [31:0] rdt, input int delay,
                        input logic stray, input logic use_err, input logic [31:0] rs2m);
    bus_t  b;
    done_t d;
    if (model_misaligned(f3[1:0], lsb)) begin
      exp_mis_q.push_back(1);
    end else begin
      b.adr = adr; b.sel = model_sel(f3[1:0], lsb); b.dat = model_dat(f3[1:0], rs2m); b.we = we;
      exp_bus_q.push_back(b);
      if (use_err) exp_err_q.push_back(1);
      else begin
        d.is_load = !we; d.rd = model_load(rdt, lsb, f3[1:0], f3[2]);
        exp_done_q.push_back(d);
      end
    end
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_lsb = lsb; i_adr = adr;
    tick();
    i_req = 1'b0; i_we = 1'($urandom); i_funct3 = 3'($urandom); i_lsb = 2'($urandom); i_adr = $urandom;
    if (model_misaligned(f3[1:0], lsb)) begin
      tick(); tick();
      check("misalign_stays_idle", o_busy, 1'b0);
    end else begin
      for (int k = 0; k < delay; k++) begin
        i_req = stray && (k == 0);
        tick();
        i_req = 1'b0;
      end
      i_dbus_rdt = rdt;
`ifdef SERV_DBUS_ERR_EN
      i_dbus_err = use_err;
      i_dbus_ack = use_err ? 1'($urandom_range(0, 1)) : 1'b1;
`else
      i_dbus_ack = 1'b1;
`endif
      tick();
      i_dbus_ack = 1'b0;
`ifdef SERV_DBUS_ERR_EN
      i_dbus_err = 1'b0;
`endif
      i_dbus_rdt = $urandom;
      wait_idle("op_ends_idle");
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic cyc_prev, rd_active, expect_idle;
    bus_t cur_bus;
    done_t d;
    int nbits;
    logic [31:0] rd_word, rd_exp;
    cyc_prev = 1'b0; rd_active = 1'b0; expect_idle = 1'b0; nbits = 0;
    rd_word = 32'h0; rd_exp = 32'h0;
    cur_bus = '{32'h0, 4'h0, 32'h0, 1'b0};
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        cyc_prev = 1'b0; rd_active = 1'b0; expect_idle = 1'b0;
      end else begin
        if (expect_idle) begin
          check("idle_after_rdout", o_busy, 1'b0);
          expect_idle = 1'b0;
        end
        if (o_dbus_cyc && !cyc_prev) begin
          check("bus_cycle_expected", exp_bus_q.size() > 0, 1'b1);
          if (exp_bus_q.size() > 0) cur_bus = exp_bus_q.pop_front();
        end
        if (o_dbus_cyc) begin
          check("bus_adr", o_dbus_adr, cur_bus.adr);
          check("bus_sel", o_dbus_sel, cur_bus.sel);
          check("bus_we", o_dbus_we, cur_bus.we);
          if (cur_bus.we) check("bus_dat", o_dbus_dat, cur_bus.dat);
        end
        if (o_misalign) begin
          check("misalign_expected", exp_mis_q.size() > 0, 1'b1);
          if (exp_mis_q.size() > 0) void'(exp_mis_q.pop_front());
          check("misalign_no_cyc", o_dbus_cyc, 1'b0);
        end
        if (o_done) begin
          check("done_expected", exp_done_q.size() > 0, 1'b1);
          if (exp_done_q.size() > 0) begin
            d = exp_done_q.pop_front();
            check("done_cyc_dropped", o_dbus_cyc, 1'b0);
            check("busy_after_done", o_busy, d.is_load);
            if (d.is_load) begin
              rd_active = 1'b1; nbits = 0; rd_word = 32'h0; rd_exp = d.rd;
            end
          end
        end
`ifdef SERV_DBUS_ERR_EN
        if (o_dbus_err) begin
          check("err_expected", exp_err_q.size() > 0, 1'b1);
          if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
          check("err_cyc_dropped", o_dbus_cyc, 1'b0);
          check("err_skips_rdout", o_busy, 1'b0);
        end
`endif
        if (rd_active) begin
          if (i_en) begin
            rd_word[nbits] = o_rd[0];
            nbits++;
            if (nbits == 32) begin
              check("load_result", rd_word, rd_exp);
              rd_active = 1'b0;
              expect_idle = 1'b1;
            end
          end
        end else begin
          check("rd_zero_outside_rdout", o_rd, 1'b0);
        end
        cyc_prev = o_dbus_cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rs2v;
    logic        we;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    i_rst_n = 1'b0; i_en = 1'b0; i_wdat_en = 1'b0; i_rs2 = 1'b0; i_req = 1'b0;
    i_we = 1'b0; i_funct3 = 3'b0; i_lsb = 2'b0; i_adr = 32'h0;
    i_dbus_rdt = 32'h0; i_dbus_ack = 1'b0;
`ifdef SERV_DBUS_ERR_EN
    i_dbus_err = 1'b0;
`endif
    #3;
    check("reset_cyc", o_dbus_cyc, 1'b0);
    check("reset_busy", o_busy, 1'b0);
    check("reset_bus_outs", {o_dbus_adr ^ o_dbus_dat, o_dbus_sel, o_dbus_we}, 32'h0);
    check("reset_adr", o_dbus_adr, 32'h0);
    check("reset_pulses", {o_done, o_misalign, o_rd}, 32'h0);
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    check("post_reset_busy", o_busy, 1'b0);
    check("post_reset_dat", o_dbus_dat, 32'h0);

    // Store byte at lsb 2, ack after 3 wait cycles.
    shift_rs2(32'hA1B2_C3D4);
    run_op(1'b1, 3'b000, 2'd2, 32'h0000_1000, 32'h0, 3, 1'b1, 1'b0, 32'hA1B2_C3D4);
    // Signed half load at lsb 2.
    run_op(1'b0, 3'b001, 2'd2, 32'h0000_2004, 32'h8F01_1234, 1, 1'b1, 1'b0, 32'h0);
    // Unsigned byte load at lsb 3.
    run_op(1'b0, 3'b100, 2'd3, 32'h0000_3008, 32'h8012_3456, 0, 1'b0, 1'b0, 32'h0);
    // Misaligned word store refused; shift register must be left untouched.
    shift_rs2(32'h1357_9BDF);
    run_op(1'b1, 3'b010, 2'd1, 32'h0000_4000, 32'h0, 0, 1'b0, 1'b0, 32'h1357_9BDF);
    run_op(1'b1, 3'b010, 2'd0, 32'h0000_4000, 32'h0, 2, 1'b1, 1'b0, 32'h1357_9BDF);
    // Signed byte load and word load at minimum latency.
    run_op(1'b0, 3'b000, 2'd1, 32'h0000_5000, 32'h1234_F678, 0, 1'b0, 1'b0, 32'h0);
    run_op(1'b0, 3'b010, 2'd0, 32'h0000_5004, 32'hCAFE_BABE, 0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a bus cycle, then a late ack.
    shift_rs2(32'h0F0F_55AA);
    exp_bus_q.push_back('{32'h0000_6000, 4'b1111, 32'h0F0F_55AA, 1'b1});
    i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_lsb = 2'd0; i_adr = 32'h0000_6000;
    tick();
    i_req = 1'b0;
    tick();
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_reset_cyc", o_dbus_cyc, 1'b0);
    check("async_reset_busy", o_busy, 1'b0);
    check("async_reset_outs", {o_dbus_sel, o_dbus_we, o_done, o_misalign, o_rd}, 32'h0);
    check("async_reset_adr", o_dbus_adr, 32'h0);
    tick();
    i_rst_n = 1'b1;
    i_dbus_ack = 1'b1;
    tick();
    i_dbus_ack = 1'b0;
    tick();
    check("late_ack_no_done", o_done, 1'b0);
    check("late_ack_no_cyc", o_dbus_cyc, 1'b0);
    check("late_ack_idle", o_busy, 1'b0);

`ifdef SERV_DBUS_ERR_EN
    // Error together with ack on a load: error wins, no read-out.
    run_op(1'b0, 3'b010, 2'd0, 32'h0000_7000, 32'hDEAD_BEEF, 1, 1'b0, 1'b1, 32'h0);
    shift_rs2(32'h2468_ACE0);
    run_op(1'b1, 3'b001, 2'd2, 32'h0000_7004, 32'h0, 0, 1'b0, 1'b1, 32'h2468_ACE0);
`endif

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      lsb = 2'($urandom_range(0, 3));
      rs2v = $urandom;
      if (we) shift_rs2(rs2v);
      run_op(we, f3, lsb, $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 4),
             1'($urandom_range(0, 1)), 1'b0, rs2v);
    end

    tick(); tick(); tick();
    check("bus_queue_drained", exp_bus_q.size(), 32'd0);
    check("done_queue_drained", exp_done_q.size(), 32'd0);
    check("misalign_queue_drained", exp_mis_q.size(), 32'd0);
    check("err_queue_drained", exp_err_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
